// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared definitions for the PWM duty sequencers: ramp state encodings.
package pwm_fade_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } fade_state_t;

endpackage

// File: rtl/pwm_frame_tick.sv
// Frame/step prescaler: fcnt free-runs over one PWM frame, scnt counts frames
// per duty step. frame and step_tick are decoded from the counter registers.
module pwm_frame_tick #(
  parameter int period   = 7,
  parameter int step_div = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic scnt_clr,
  output logic frame,
  output logic step_tick
);

  localparam int FW = (period > 1) ? $clog2(period) : 1;
  localparam int SW = (step_div > 1) ? $clog2(step_div) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(period - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(step_div - 1);

  logic [FW-1:0] fcnt;
  logic [SW-1:0] scnt;

  assign frame     = (fcnt == FCNT_LAST);
  assign step_tick = frame && (scnt == SCNT_LAST);

  // Frame counter is never touched by the handshake so the pwm frame phase is stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt <= '0;
    end else if (frame) begin
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
    end else if (scnt_clr) begin
      scnt <= '0;
    end else if (frame) begin
      scnt <= (scnt == SCNT_LAST) ? '0 : scnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty ramp sequencer for a pwm block: walks duty one LSB per step_div frames
// toward the accepted target. Optional PWM_FADE_RETARGET_EN allows retargeting mid-ramp.
module pwm_fade_ctrl
  import pwm_fade_ctrl_pkg::*;
#(
  parameter int period   = 7,
  parameter int step_div = 4,
  localparam int DW      = $clog2(period + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] tgt,
  input  logic          tgt_valid,
  output logic          tgt_ready,
  output logic [DW-1:0] duty,
  output logic          frame,
  output logic          busy,
  output logic          done
);

  localparam logic [DW-1:0] DUTY_MAX = DW'(period);

  fade_state_t   state;
  logic [DW-1:0] tgt_q;
  logic [DW-1:0] tgt_lim;
  logic [DW-1:0] duty_inc;
  logic [DW-1:0] duty_dec;
  logic          accept;
  logic          scnt_clr;
  logic          step_tick;

  function automatic logic [DW-1:0] clamp_duty(input logic [DW-1:0] t);
    return (t > DUTY_MAX) ? DUTY_MAX : t;
  endfunction

  assign tgt_lim = clamp_duty(tgt);

`ifdef PWM_FADE_RETARGET_EN
  assign tgt_ready = 1'b1;
`else
  assign tgt_ready = (state == ST_IDLE);
`endif

  assign busy     = (state != ST_IDLE);
  assign accept   = tgt_valid && tgt_ready;
  // A retarget while busy keeps the step phase; only a fresh ramp restarts it.
  assign scnt_clr = accept && (state == ST_IDLE);
  assign duty_inc = duty + 1'b1;
  assign duty_dec = duty - 1'b1;

  pwm_frame_tick #(
    .period   (period),
    .step_div (step_div)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .scnt_clr  (scnt_clr),
    .frame     (frame),
    .step_tick (step_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      duty  <= '0;
      tgt_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        tgt_q <= tgt_lim;
        if (tgt_lim == duty) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end else if (tgt_lim > duty) begin
          state <= ST_UP;
        end else begin
          state <= ST_DOWN;
        end
      end else if (step_tick) begin
        // tgt_q is clamped to 0..period, so the step can never wrap duty.
        case (state)
          ST_UP: begin
            duty <= duty_inc;
            if (duty_inc == tgt_q) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
          ST_DOWN: begin
            duty <= duty_dec;
            if (duty_dec == tgt_q) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl (period=7/step_div=2, plus a period=5 instance for clamping).
module tb_pwm_fade_ctrl;

  localparam int P       = 7;
  localparam int SD      = 2;
  localparam int SPACING = P * SD;
  localparam int P5      = 5;

  logic       clk;
  logic       rst;
  logic [2:0] tgt;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [2:0] duty;
  logic       frame;
  logic       busy;
  logic       done;

  logic [2:0] tgt5;
  logic       tgt5_valid;
  logic       tgt5_ready;
  logic [2:0] duty5;
  logic       frame5;
  logic       busy5;
  logic       done5;

  int checks;
  int errors;
  int cyc;

  pwm_fade_ctrl #(.period(P), .step_div(SD)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt       (tgt),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .duty      (duty),
    .frame     (frame),
    .busy      (busy),
    .done      (done)
  );

  pwm_fade_ctrl #(.period(P5), .step_div(SD)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .tgt       (tgt5),
    .tgt_valid (tgt5_valid),
    .tgt_ready (tgt5_ready),
    .duty      (duty5),
    .frame     (frame5),
    .busy      (busy5),
    .done      (done5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset release; the frame counter phase is cyc % period.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] v, output int first_lat);
    int f0;
    f0 = cyc % P;
    checks++;
    if (frame !== (f0 == P - 1)) begin
      errors++;
      $display("FAIL offer_frame: got %b, want %b", frame, (f0 == P - 1));
    end
    tgt       = v;
    tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
    first_lat = ((f0 == P - 1) ? P : (P - 1 - f0)) + (SD - 1) * P + 1;
  endtask

  task automatic watch_ramp(input int final_d, input int exp_steps, input int first_lat);
    int prev;
    int dir;
    int steps;
    int last_k;
    bit fin;
    prev   = int'(duty);
    dir    = (final_d > prev) ? 1 : -1;
    steps  = 0;
    last_k = 0;
    fin    = 1'b0;
    for (int k = 1; k <= 10 * SPACING && !fin; k++) begin
      checks++;
      if (frame !== (cyc % P == P - 1)) begin
        errors++;
        $display("FAIL ramp_frame: got %b, want %b at cycle %0d", frame, (cyc % P == P - 1), k);
      end
      if (int'(duty) != prev) begin
        steps++;
        checks++;
        if (int'(duty) != prev + dir) begin
          errors++;
          $display("FAIL ramp_step: got duty %0d, want %0d", duty, prev + dir);
        end
        checks++;
        if (steps == 1) begin
          if (k != first_lat) begin
            errors++;
            $display("FAIL ramp_first_latency: got %0d, want %0d", k, first_lat);
          end
        end else if (k - last_k != SPACING) begin
          errors++;
          $display("FAIL ramp_spacing: got %0d, want %0d", k - last_k, SPACING);
        end
        checks++;
        if (int'(duty) == final_d) begin
          fin = 1'b1;
          if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ramp_done: got done=%b busy=%b, want done=1 busy=0", done, busy);
          end
        end else if (done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL ramp_mid: got done=%b busy=%b, want done=0 busy=1", done, busy);
        end
        last_k = k;
        prev   = int'(duty);
      end else begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL ramp_hold: got done=%b busy=%b, want done=0 busy=1", done, busy);
        end
      end
      if (!fin) tick();
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL ramp_timeout: got duty %0d, want %0d", duty, final_d);
    end
    checks++;
    if (steps != exp_steps) begin
      errors++;
      $display("FAIL ramp_steps: got %0d, want %0d", steps, exp_steps);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (duty !== 3'd0) begin errors++; $display("FAIL reset_duty: got %0d, want 0", duty); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_done: got busy=%b done=%b, want 0 0", busy, done);
    end
    checks++;
    if (tgt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, want 1", tgt_ready); end
    checks++;
    if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b, want 0", frame); end
    checks++;
    if (duty5 !== 3'd0 || busy5 !== 1'b0 || tgt5_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_dut5: got duty=%0d busy=%b ready=%b, want 0 0 1", duty5, busy5, tgt5_ready);
    end
  endtask

  task automatic test_ramp_up();
    int lat;
    checks++;
    if (tgt_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL up_idle: got ready=%b busy=%b, want 1 0", tgt_ready, busy);
    end
    offer(3'd3, lat);
    watch_ramp(3, 3, lat);
  endtask

  task automatic test_equal_target();
    int lat;
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL eq_done_clear: got %b, want 0", done); end
    offer(3'd3, lat);
    checks++;
    if (done !== 1'b1 || duty !== 3'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL eq_done: got done=%b duty=%0d busy=%b, want 1 3 0", done, duty, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || duty !== 3'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL eq_after: got done=%b duty=%0d busy=%b, want 0 3 0", done, duty, busy);
    end
  endtask

  task automatic test_up_down();
    int lat;
    tick();
    offer(3'd6, lat);
    watch_ramp(6, 3, lat);
    tick();
    offer(3'd1, lat);
    watch_ramp(1, 5, lat);
  endtask

  task automatic test_retarget();
    int lat;
    int dones;
    int changes;
    int first_dir;
    int prev;
    int exp_final;
    tick();
    offer(3'd6, lat);
    for (int k = 0; k < 100 && duty !== 3'd3; k++) tick();
    checks++;
    if (duty !== 3'd3) begin errors++; $display("FAIL rt_reach: got %0d, want 3", duty); end
    checks++;
`ifdef PWM_FADE_RETARGET_EN
    exp_final = 0;
    if (tgt_ready !== 1'b1) begin errors++; $display("FAIL rt_ready: got %b, want 1", tgt_ready); end
`else
    exp_final = 6;
    if (tgt_ready !== 1'b0) begin errors++; $display("FAIL rt_ready: got %b, want 0", tgt_ready); end
`endif
    tgt       = 3'd0;
    tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
    prev      = 3;
    dones     = 0;
    changes   = 0;
    first_dir = 0;
    for (int k = 0; k < 120; k++) begin
      if (done === 1'b1) dones++;
      if (int'(duty) != prev) begin
        if (changes == 0) first_dir = int'(duty) - prev;
        changes++;
        prev = int'(duty);
      end
      tick();
    end
    checks++;
    if (int'(duty) != exp_final) begin errors++; $display("FAIL rt_final: got %0d, want %0d", duty, exp_final); end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL rt_dones: got %0d, want 1", dones); end
    checks++;
    if (first_dir != ((exp_final > 3) ? 1 : -1)) begin
      errors++;
      $display("FAIL rt_dir: got %0d, want %0d", first_dir, (exp_final > 3) ? 1 : -1);
    end
    checks++;
    if (changes != 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rt_steps: got %0d steps busy=%b, want 3 steps busy=0", changes, busy);
    end
  endtask

  task automatic test_clamp();
    int steps;
    int prev;
    bit fin;
    bit over;
    checks++;
    if (tgt5_ready !== 1'b1 || duty5 !== 3'd0) begin
      errors++;
      $display("FAIL clamp_idle: got ready=%b duty=%0d, want 1 0", tgt5_ready, duty5);
    end
    tgt5       = 3'd7;
    tgt5_valid = 1'b1;
    tick();
    tgt5_valid = 1'b0;
    prev  = 0;
    steps = 0;
    fin   = 1'b0;
    over  = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      if (int'(duty5) > P5) over = 1'b1;
      if (int'(duty5) != prev) begin
        steps++;
        prev = int'(duty5);
      end
      checks++;
      if (frame5 !== (cyc % P5 == P5 - 1)) begin
        errors++;
        $display("FAIL clamp_frame: got %b, want %b", frame5, (cyc % P5 == P5 - 1));
      end
      if (done5 === 1'b1) fin = 1'b1;
      else tick();
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL clamp_timeout: got duty %0d, want 5", duty5); end
    checks++;
    if (duty5 !== 3'd5 || steps != 5 || over) begin
      errors++;
      $display("FAIL clamp_final: got duty=%0d steps=%0d over=%b, want 5 5 0", duty5, steps, over);
    end
    tick();
    checks++;
    if (duty5 !== 3'd5 || busy5 !== 1'b0 || done5 !== 1'b0) begin
      errors++;
      $display("FAIL clamp_stop: got duty=%0d busy=%b done=%b, want 5 0 0", duty5, busy5, done5);
    end
  endtask

  task automatic test_reset_mid_ramp();
    int lat;
    tick();
`ifdef PWM_FADE_RETARGET_EN
    offer(3'd7, lat);
`else
    offer(3'd0, lat);
`endif
    for (int k = 0; k < 200 && duty !== 3'd4; k++) tick();
    checks++;
    if (duty !== 3'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_reach: got duty=%0d busy=%b, want 4 1", duty, busy);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (duty !== 3'd0) begin errors++; $display("FAIL rstmid_duty: got %0d, want 0", duty); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_busy_done: got busy=%b done=%b, want 0 0", busy, done);
    end
    checks++;
    if (tgt_ready !== 1'b1 || frame !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready_frame: got ready=%b frame=%b, want 1 0", tgt_ready, frame);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || duty !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_release: got done=%b duty=%0d, want 0 0", done, duty);
    end
    offer(3'd2, lat);
    watch_ramp(2, 2, lat);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    tgt        = 3'd0;
    tgt_valid  = 1'b0;
    tgt5       = 3'd0;
    tgt5_valid = 1'b0;
    #1 rst = 1'b1;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    test_ramp_up();
    test_equal_target();
    test_up_down();
    test_retarget();
    test_clamp();
    test_reset_mid_ramp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
